// File: rtl/ahb_mem_arbiter.sv
// Two-master AHB-Lite arbiter in front of a single shared memory slave.
// Each master port registers one address phase into a hold register, the
// arbiter issues held transfers to the slave (round-robin or fixed priority),
// and the data phase of one port overlaps the address phase of the other.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | no transfer held, master sees HREADY=1
// ST_PEND | address phase captured, waiting to be issued to the slave
// ST_DATA | transfer issued, port owns the slave data phase
module ahb_mem_arbiter #(
  parameter int ARB_MODE = 0
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        M0_HSEL,
  input  logic [31:0] M0_HADDR,
  input  logic [1:0]  M0_HTRANS,
  input  logic        M0_HWRITE,
  input  logic [2:0]  M0_HSIZE,
  input  logic [31:0] M0_HWDATA,
  output logic        M0_HREADY,
  output logic [31:0] M0_HRDATA,
  input  logic        M1_HSEL,
  input  logic [31:0] M1_HADDR,
  input  logic [1:0]  M1_HTRANS,
  input  logic        M1_HWRITE,
  input  logic [2:0]  M1_HSIZE,
  input  logic [31:0] M1_HWDATA,
  output logic        M1_HREADY,
  output logic [31:0] M1_HRDATA,
  output logic        S_HSEL,
  output logic [31:0] S_HADDR,
  output logic [1:0]  S_HTRANS,
  output logic        S_HWRITE,
  output logic [2:0]  S_HSIZE,
  output logic [31:0] S_HWDATA,
  output logic        S_HREADY,
  input  logic        S_HREADYOUT,
  input  logic [31:0] S_HRDATA
);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_PEND = 2'd1, ST_DATA = 2'd2} port_st_t;

  port_st_t    st_q [2];
  port_st_t    st_d [2];
  logic [1:0]  hsel_in;
  logic [1:0]  trans_act;
  logic [31:0] addr_in [2];
  logic [1:0]  write_in;
  logic [2:0]  size_in [2];
  logic [1:0]  port_rdy;
  logic [1:0]  cap;
  logic [1:0]  pend;
  logic [1:0]  grant;
  logic        issue;
  logic        win;
  logic [31:0] hold_addr_q [2];
  logic [1:0]  hold_wr_q;
  logic [2:0]  hold_size_q [2];
  logic        own_vld_q;
  logic        own_id_q;
  logic        last_q;
  // only HTRANS[1] distinguishes active from IDLE/BUSY; SEQ is issued as NONSEQ
  logic        unused_htrans;

  assign unused_htrans = M0_HTRANS[0] ^ M1_HTRANS[0];
  assign hsel_in    = {M1_HSEL, M0_HSEL};
  assign trans_act  = {M1_HTRANS[1], M0_HTRANS[1]};
  assign write_in   = {M1_HWRITE, M0_HWRITE};
  assign addr_in[0] = M0_HADDR;
  assign addr_in[1] = M1_HADDR;
  assign size_in[0] = M0_HSIZE;
  assign size_in[1] = M1_HSIZE;

  // Per-port ready, capture qualifier and pending flag
  always_comb begin
    port_rdy = '0;
    cap      = '0;
    pend     = '0;
    for (int i = 0; i < 2; i++) begin
      port_rdy[i] = (st_q[i] == ST_IDLE) || ((st_q[i] == ST_DATA) && S_HREADYOUT);
      cap[i]      = hsel_in[i] && trans_act[i] && port_rdy[i];
      pend[i]     = (st_q[i] == ST_PEND);
    end
  end

  // Winner select: a tie goes to the port not granted last, or to M0 in fixed mode
  always_comb begin
    issue = S_HREADYOUT && (pend != 2'b00);
    if (pend == 2'b11) win = (ARB_MODE == 1) ? 1'b0 : ~last_q;
    else               win = pend[1];
    grant = '0;
    if (issue) grant[win] = 1'b1;
  end

  // Port state registers
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      for (int i = 0; i < 2; i++) st_q[i] <= ST_IDLE;
    end else begin
      for (int i = 0; i < 2; i++) st_q[i] <= st_d[i];
    end
  end

  // Port next-state logic; completion and a fresh capture may share one edge
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      st_d[i] = st_q[i];
      case (st_q[i])
        ST_IDLE: if (cap[i]) st_d[i] = ST_PEND;
        ST_PEND: if (grant[i]) st_d[i] = ST_DATA;
        ST_DATA: if (S_HREADYOUT) st_d[i] = cap[i] ? ST_PEND : ST_IDLE;
        default: st_d[i] = ST_IDLE;
      endcase
    end
  end

  // Hold registers, data-phase owner and last-grant pointer
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      for (int i = 0; i < 2; i++) begin
        hold_addr_q[i] <= '0;
        hold_size_q[i] <= '0;
      end
      hold_wr_q <= '0;
      own_vld_q <= 1'b0;
      own_id_q  <= 1'b0;
      last_q    <= 1'b1;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (cap[i]) begin
          hold_addr_q[i] <= addr_in[i];
          hold_wr_q[i]   <= write_in[i];
          hold_size_q[i] <= size_in[i];
        end
      end
      if (issue) begin
        own_vld_q <= 1'b1;
        own_id_q  <= win;
        last_q    <= win;
      end else if (own_vld_q && S_HREADYOUT) begin
        own_vld_q <= 1'b0;
      end
    end
  end

  // Master and slave side outputs
  always_comb begin
    M0_HREADY = port_rdy[0];
    M1_HREADY = port_rdy[1];
    M0_HRDATA = (own_vld_q && !own_id_q) ? S_HRDATA : 32'h0;
    M1_HRDATA = (own_vld_q &&  own_id_q) ? S_HRDATA : 32'h0;
    S_HSEL    = issue;
    S_HTRANS  = issue ? 2'b10 : 2'b00;
    S_HADDR   = issue ? hold_addr_q[win] : 32'h0;
    S_HWRITE  = issue ? hold_wr_q[win] : 1'b0;
    S_HSIZE   = issue ? hold_size_q[win] : 3'b000;
    S_HREADY  = S_HREADYOUT;
    S_HWDATA  = own_vld_q ? (own_id_q ? M1_HWDATA : M0_HWDATA) : 32'h0;
  end

endmodule
